// File: rtl/wt_bcd_join_if.sv
// Digit-entry / result handshake bundle for the BCD joiner.
// The master side drives the digits, commands and ready signal.
// The slave side is the joiner, which returns the result, status and display echo.
interface wt_bcd_join_if;
  logic [3:0] digit_in;
  logic       digit_stb;
  logic       commit;
  logic       clear;
  logic [6:0] number;
  logic       num_valid;
  logic       num_ready;
  logic       err;
  logic [3:0] disp_a;
  logic [3:0] disp_b;
  logic       busy;

  modport master (
    output digit_in, digit_stb, commit, clear, num_ready,
    input  number, num_valid, err, disp_a, disp_b, busy
  );

  modport slave (
    input  digit_in, digit_stb, commit, clear, num_ready,
    output number, num_valid, err, disp_a, disp_b, busy
  );
endinterface

// File: rtl/wt_bcd_join.sv
// Digit-entry accumulator and BCD-to-binary joiner for time/alarm fields.
// It collects up to two decimal digits and echoes them as tens/ones.
// On commit it emits tens*10+ones over a valid/ready handshake.
//
// state | meaning
// EMPTY | no digits entered, display shows 00
// ONE   | one digit entered (held in ones)
// TWO   | two digits entered, further digits shift left
// CONV  | one-cycle range check and conversion
// OUT   | result valid, waiting for the consumer
module wt_bcd_join #(
  parameter int MAX_VALUE = 59
) (
  input logic         clk,
  input logic         reset,
  wt_bcd_join_if.slave bus
);

  typedef enum logic [2:0] {EMPTY, ONE, TWO, CONV, OUT} state_t;

  state_t     state, state_n;
  logic [3:0] disp_a, disp_a_n;
  logic [3:0] disp_b, disp_b_n;
  logic [6:0] number, number_n;
  logic       err, err_n;
  logic       digit_ok;
  logic [6:0] val;

  assign digit_ok = (bus.digit_in <= 4'd9);
  // Multiply by ten as shifts; the maximum is 99, so the result fits in 7 bits.
  assign val = {disp_a, 3'b000} + {2'b00, disp_a, 1'b0} + {3'b000, disp_b};

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      disp_a <= 4'd0;
      disp_b <= 4'd0;
      number <= 7'd0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      disp_a <= disp_a_n;
      disp_b <= disp_b_n;
      number <= number_n;
      err    <= err_n;
    end
  end

  // Next state and next values. Priority is clear, then commit, then digit strobe.
  always_comb begin
    state_n  = state;
    disp_a_n = disp_a;
    disp_b_n = disp_b;
    number_n = number;
    err_n    = 1'b0;
    if (bus.clear) begin
      state_n  = EMPTY;
      disp_a_n = 4'd0;
      disp_b_n = 4'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (bus.commit) begin
            err_n = 1'b1;
          end else if (bus.digit_stb) begin
            if (digit_ok) begin
              disp_a_n = 4'd0;
              disp_b_n = bus.digit_in;
              state_n  = ONE;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        ONE, TWO: begin
          if (bus.commit) begin
            state_n = CONV;
          end else if (bus.digit_stb) begin
            if (digit_ok) begin
              disp_a_n = disp_b;
              disp_b_n = bus.digit_in;
              state_n  = TWO;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        CONV: begin
          if (val <= 7'(MAX_VALUE)) begin
            number_n = val;
            state_n  = OUT;
          end else begin
            err_n    = 1'b1;
            disp_a_n = 4'd0;
            disp_b_n = 4'd0;
            state_n  = EMPTY;
          end
        end
        OUT: begin
          if (bus.num_ready) begin
            disp_a_n = 4'd0;
            disp_b_n = 4'd0;
            state_n  = EMPTY;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  assign bus.number    = number;
  assign bus.num_valid = (state == OUT);
  assign bus.err       = err;
  assign bus.disp_a    = disp_a;
  assign bus.disp_b    = disp_b;
  assign bus.busy      = (state == CONV) || (state == OUT);

endmodule

// File: tb/tb_wt_bcd_join.sv
// Bench for wt_bcd_join. Three instances (MAX 59, 23, 99) share one stimulus stream.
// A behavioural model predicts every output, and a compare process checks each falling edge.
// Directed literal checks pin the model against known values.
module tb_wt_bcd_join;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit_in = 4'd0;
  logic       digit_stb = 1'b0;
  logic       commit = 1'b0;
  logic       clear = 1'b0;
  logic       rdy = 1'b0;
  bit         started = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wt_bcd_join_if if0 ();
  wt_bcd_join_if if1 ();
  wt_bcd_join_if if2 ();

  assign if0.digit_in = digit_in;  assign if1.digit_in = digit_in;  assign if2.digit_in = digit_in;
  assign if0.digit_stb = digit_stb; assign if1.digit_stb = digit_stb; assign if2.digit_stb = digit_stb;
  assign if0.commit = commit;      assign if1.commit = commit;      assign if2.commit = commit;
  assign if0.clear = clear;        assign if1.clear = clear;        assign if2.clear = clear;
  assign if0.num_ready = rdy;      assign if1.num_ready = rdy;      assign if2.num_ready = rdy;

  wt_bcd_join #(.MAX_VALUE(59)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  wt_bcd_join #(.MAX_VALUE(23)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  wt_bcd_join #(.MAX_VALUE(99)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  // Behavioural model: digit count, tens/ones, pending conversion, held result.
  int   m_max [3] = '{59, 23, 99};
  int   m_cnt [3];
  int   m_tens[3];
  int   m_ones[3];
  bit   m_pend[3];
  bit   m_hold[3];
  bit   m_err [3];
  int   m_num [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_cnt[k] = 0; m_tens[k] = 0; m_ones[k] = 0;
        m_pend[k] = 0; m_hold[k] = 0; m_err[k] = 0; m_num[k] = 0;
      end else begin
        m_err[k] = 0;
        if (clear) begin
          m_cnt[k] = 0; m_tens[k] = 0; m_ones[k] = 0;
          m_pend[k] = 0; m_hold[k] = 0;
        end else if (m_pend[k]) begin
          m_pend[k] = 0;
          if (m_tens[k] * 10 + m_ones[k] <= m_max[k]) begin
            m_num[k]  = m_tens[k] * 10 + m_ones[k];
            m_hold[k] = 1;
          end else begin
            m_err[k] = 1; m_tens[k] = 0; m_ones[k] = 0; m_cnt[k] = 0;
          end
        end else if (m_hold[k]) begin
          if (rdy) begin
            m_hold[k] = 0; m_tens[k] = 0; m_ones[k] = 0; m_cnt[k] = 0;
          end
        end else if (commit) begin
          if (m_cnt[k] == 0) m_err[k] = 1;
          else m_pend[k] = 1;
        end else if (digit_stb) begin
          if (digit_in > 9) m_err[k] = 1;
          else begin
            m_tens[k] = (m_cnt[k] == 0) ? 0 : m_ones[k];
            m_ones[k] = int'(digit_in);
            m_cnt[k]  = (m_cnt[k] >= 1) ? 2 : 1;
          end
        end
      end
    end
  end

  task automatic cmp_inst(input int k, input logic [6:0] n, input logic v, input logic e,
                          input logic [3:0] a, input logic [3:0] b, input logic bz);
    logic [18:0] act, exp;
    act = {n, v, e, a, b, bz};
    exp = {7'(m_num[k]), m_hold[k], m_err[k], 4'(m_tens[k]), 4'(m_ones[k]), m_pend[k] | m_hold[k]};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model_cmp inst%0d t=%0t: got {num,vld,err,a,b,busy}=%h exp %h", k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp_inst(0, if0.number, if0.num_valid, if0.err, if0.disp_a, if0.disp_b, if0.busy);
      cmp_inst(1, if1.number, if1.num_valid, if1.err, if1.disp_a, if1.disp_b, if1.busy);
      cmp_inst(2, if2.number, if2.num_valid, if2.err, if2.disp_a, if2.disp_b, if2.busy);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock cycle with the given inputs. It returns at the following falling edge.
  task automatic cyc(input logic stb, input logic [3:0] d, input logic cmt, input logic clr);
    digit_stb = stb; digit_in = d; commit = cmt; clear = clr;
    @(posedge clk);
    @(negedge clk);
    digit_stb = 1'b0; commit = 1'b0; clear = 1'b0;
  endtask

  task automatic dig(input logic [3:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    started = 1'b1;
    chk("reset_valid", int'(if0.num_valid), 0);
    chk("reset_disp", int'({if0.disp_a, if0.disp_b}), 0);
    chk("reset_num_busy", int'({if0.number, if0.busy}), 0);

    // Test 1: 45 held while ready is low, then accepted.
    dig(4); dig(5);
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    chk("t1_busy_conv", int'(if0.busy), 1);
    chk("t1_not_yet", int'(if0.num_valid), 0);
    idle();
    chk("t1_valid", int'(if0.num_valid), 1);
    chk("t1_num", int'(if0.number), 45);
    idle();
    chk("t1_hold", int'(if0.number), 45);
    rdy = 1'b1; idle(); rdy = 1'b0;
    chk("t1_accept", int'({if0.num_valid, if0.busy, if0.disp_a, if0.disp_b}), 0);

    // Test 2: 72 is out of range for 59 and 23, and accepted for 99.
    dig(7); dig(2); cyc(1'b0, 4'd0, 1'b1, 1'b0); idle();
    chk("t2_err59", int'(if0.err), 1);
    chk("t2_err23", int'(if1.err), 1);
    chk("t2_novalid", int'(if0.num_valid), 0);
    chk("t2_disp0", int'({if0.disp_a, if0.disp_b}), 0);
    chk("t2_num99", int'(if2.number), 72);
    rdy = 1'b1; idle(); rdy = 1'b0;
    chk("t2_err_pulse", int'(if0.err), 0);
    dig(2); dig(4); cyc(1'b0, 4'd0, 1'b1, 1'b0); idle();
    chk("t2_24_err23", int'(if1.err), 1);
    rdy = 1'b1; idle(); rdy = 1'b0;
    dig(2); dig(3); cyc(1'b0, 4'd0, 1'b1, 1'b0); idle();
    chk("t2_23_num", int'(if1.number), 23);
    rdy = 1'b1; idle(); rdy = 1'b0;

    // Test 3: with three digits the oldest is dropped; a single digit commit gives tens 0.
    dig(1); dig(2); dig(3);
    chk("t3_disp", int'({if0.disp_a, if0.disp_b}), 8'h23);
    cyc(1'b0, 4'd0, 1'b1, 1'b0); idle();
    chk("t3_num23", int'(if0.number), 23);
    rdy = 1'b1; idle(); rdy = 1'b0;
    dig(9); cyc(1'b0, 4'd0, 1'b1, 1'b0); idle();
    chk("t3_num9", int'(if0.number), 9);
    rdy = 1'b1; idle(); rdy = 1'b0;

    // Test 4: rejected inputs, and commit taking priority over a digit strobe.
    dig(12);
    chk("t4_bad_digit_err", int'(if0.err), 1);
    chk("t4_bad_digit_disp", int'({if0.disp_a, if0.disp_b}), 0);
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    chk("t4_empty_commit_err", int'(if0.err), 1);
    dig(5); cyc(1'b1, 4'd7, 1'b1, 1'b0); idle();
    chk("t4_commit_wins", int'(if0.number), 5);

    // Test 5: clear while valid, digits ignored in OUT, and ready held high early.
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("t5_clear_valid", int'(if0.num_valid), 0);
    chk("t5_clear_num", int'(if0.number), 5);
    dig(3); dig(1); cyc(1'b0, 4'd0, 1'b1, 1'b0); idle();
    dig(8);
    chk("t5_out_no_err", int'(if0.err), 0);
    chk("t5_out_disp", int'({if0.disp_a, if0.disp_b}), 8'h31);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    rdy = 1'b1;
    dig(1); dig(6); cyc(1'b0, 4'd0, 1'b1, 1'b0); idle();
    chk("t5_early_valid", int'(if0.num_valid), 1);
    idle();
    chk("t5_one_cycle", int'(if0.num_valid), 0);
    rdy = 1'b0;

    // Test 6: reset in TWO and in OUT.
    dig(1); dig(2); do_reset();
    chk("t6_rst_two", int'({if0.disp_a, if0.disp_b, if0.busy, if0.err}), 0);
    dig(1); dig(2); cyc(1'b0, 4'd0, 1'b1, 1'b0); idle(); do_reset();
    chk("t6_rst_out", int'({if0.number, if0.num_valid, if0.busy}), 0);

    // Sweep all two-digit inputs on the MAX 99 instance.
    rdy = 1'b1;
    for (int a = 0; a < 10; a++) begin
      for (int b = 0; b < 10; b++) begin
        dig(4'(a)); dig(4'(b)); cyc(1'b0, 4'd0, 1'b1, 1'b0); idle();
        chk("sweep_num", int'(if2.number), a * 10 + b);
        idle();
      end
    end
    rdy = 1'b0;

    // Random traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] d;
      logic       s, c, cl;
      d  = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      s  = ($urandom_range(0, 99) < 40);
      c  = ($urandom_range(0, 99) < 15);
      cl = ($urandom_range(0, 99) < 3);
      rdy = ($urandom_range(0, 1) == 1);
      reset = ($urandom_range(0, 99) < 1);
      cyc(s, d, c, cl);
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
